data_bus_arbiter: RTL and testbench

//  Shares the single data memory bus between two masters: m0 (riscv_core load/store port) and m1
//  (auxiliary master, e.g. DMA/debug). Sits between the masters and the data memory bus.

---
 rtl/data_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_data_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter
//   Shares one data memory bus between two masters. m0 is the core load/store
//   port and m1 is an auxiliary master such as DMA or debug. One master is
//   granted per cycle, and the grant is combinational. The granted request is
//   muxed onto the bus. Read data returns to the issuing master exactly
//   READ_LATENCY cycles after the grant.
//   A master can lock the bus across several transfers. m1 is protected
//   against starvation: after MAX_STARVE consecutive denied cycles it is
//   forced to win arbitration.
// Ports
//   clock, reset                   rising-edge clock, async active-high reset
//   mN_req/write/lock              transfer request, direction, hold ownership
//   mN_address/write_data/byte_enable  transfer payload
//   mN_gnt                         transfer accepted this cycle
//   mN_rvalid/read_data            read response for master N
//   bus_address/write_data/byte_enable/read_enable/write_enable  bus request
//   bus_read_data                  read data from the memory bus
module data_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_STARVE   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    m0_req,
  input  logic                    m0_write,
  input  logic                    m0_lock,
  input  logic [ADDR_WIDTH-1:0]   m0_address,
  input  logic [DATA_WIDTH-1:0]   m0_write_data,
  input  logic [DATA_WIDTH/8-1:0] m0_byte_enable,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_read_data,
  input  logic                    m1_req,
  input  logic                    m1_write,
  input  logic                    m1_lock,
  input  logic [ADDR_WIDTH-1:0]   m1_address,
  input  logic [DATA_WIDTH-1:0]   m1_write_data,
  input  logic [DATA_WIDTH/8-1:0] m1_byte_enable,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_read_data,
  output logic [ADDR_WIDTH-1:0]   bus_address,
  output logic [DATA_WIDTH-1:0]   bus_write_data,
  output logic [DATA_WIDTH/8-1:0] bus_byte_enable,
  output logic                    bus_read_enable,
  output logic                    bus_write_enable,
  input  logic [DATA_WIDTH-1:0]   bus_read_data
);

  typedef enum logic [1:0] {ARB = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

  state_t                  state, state_nxt;
  logic [3:0]              starve_cnt;
  logic                    rd_gnt;
  logic [READ_LATENCY-1:0] vld_p;
  logic [READ_LATENCY-1:0] id_p;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STARVE_MAX) ? STARVE_MAX : v + 4'd1;
  endfunction

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ARB;
    else       state <= state_nxt;
  end

  // Next-state logic. A lock owner keeps the bus until it presents lock=0.
  // Its transfer in that same cycle is still granted.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB: begin
        if (m0_gnt && m0_lock)      state_nxt = LOCK0;
        else if (m1_gnt && m1_lock) state_nxt = LOCK1;
      end
      LOCK0:   if (!m0_lock) state_nxt = ARB;
      LOCK1:   if (!m1_lock) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Grant outputs. The starvation override outranks m0's normal priority,
  // but only in ARB. A locked m0 holds m1 off indefinitely.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      case (state)
        ARB: begin
          if (m1_req && (starve_cnt == STARVE_MAX)) m1_gnt = 1'b1;
          else if (m0_req)                          m0_gnt = 1'b1;
          else if (m1_req)                          m1_gnt = 1'b1;
        end
        LOCK0:   m0_gnt = m0_req;
        LOCK1:   m1_gnt = m1_req;
        default: ;
      endcase
    end
  end

  // Bus request mux. The bus is driven to zero when there is no grant.
  always_comb begin
    bus_address      = '0;
    bus_write_data   = '0;
    bus_byte_enable  = '0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    if (m0_gnt) begin
      bus_address      = m0_address;
      bus_write_data   = m0_write_data;
      bus_byte_enable  = m0_byte_enable;
      bus_read_enable  = ~m0_write;
      bus_write_enable = m0_write;
    end else if (m1_gnt) begin
      bus_address      = m1_address;
      bus_write_data   = m1_write_data;
      bus_byte_enable  = m1_byte_enable;
      bus_read_enable  = ~m1_write;
      bus_write_enable = m1_write;
    end
  end

  assign rd_gnt = bus_read_enable;

  // Starvation counter. It counts every cycle m1 asks and is refused,
  // including cycles while m0 holds a lock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 starve_cnt <= 4'd0;
    else if (!m1_req || m1_gnt) starve_cnt <= 4'd0;
    else                       starve_cnt <= sat_inc(starve_cnt);
  end

  // Response pipe, stage p0 .. p(READ_LATENCY-1). Each granted read carries
  // its master id, so the last stage steers bus_read_data to the issuing
  // master. Reset flushes in-flight reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
      id_p  <= '0;
    end else begin
      vld_p[0] <= rd_gnt;
      id_p[0]  <= m1_gnt;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        id_p[i]  <= id_p[i-1];
      end
    end
  end

  assign m0_rvalid    = vld_p[READ_LATENCY-1] & ~id_p[READ_LATENCY-1] & ~reset;
  assign m1_rvalid    = vld_p[READ_LATENCY-1] &  id_p[READ_LATENCY-1] & ~reset;
  assign m0_read_data = bus_read_data;
  assign m1_read_data = bus_read_data;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Testbench for data_bus_arbiter (READ_LATENCY=2, MAX_STARVE=4) with a
// scoreboard for read responses. The memory returns 0xA5000000+addr for
// locations that have never been written.
module tb_data_bus_arbiter;
  localparam int RL = 2;
  localparam int MS = 4;

  logic        clock, reset;
  logic        m0_req, m0_write, m0_lock, m1_req, m1_write, m1_lock;
  logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
  logic [3:0]  m0_byte_enable, m1_byte_enable;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_read_data, m1_read_data;
  logic [31:0] bus_address, bus_write_data, bus_read_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable, bus_write_enable;

  data_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(RL), .MAX_STARVE(MS)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_lock(m0_lock), .m0_address(m0_address),
    .m0_write_data(m0_write_data), .m0_byte_enable(m0_byte_enable), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_read_data(m0_read_data),
    .m1_req(m1_req), .m1_write(m1_write), .m1_lock(m1_lock), .m1_address(m1_address),
    .m1_write_data(m1_write_data), .m1_byte_enable(m1_byte_enable), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_read_data(m1_read_data),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_byte_enable(bus_byte_enable), .bus_read_enable(bus_read_enable),
    .bus_write_enable(bus_write_enable), .bus_read_data(bus_read_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory model with a fixed read latency of RL.
  logic [31:0]  mem [0:255];
  logic [255:0] touched;
  logic [31:0]  rd_pipe [RL];

  function automatic logic [31:0] mem_word(input logic [7:0] idx);
    return touched[idx] ? mem[idx] : 32'hA500_0000 + {22'd0, idx, 2'b00};
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clock) begin
    if (reset) touched <= '0;
    else if (bus_write_enable) begin
      mem[bus_address[9:2]]     <= be_merge(mem_word(bus_address[9:2]), bus_write_data, bus_byte_enable);
      touched[bus_address[9:2]] <= 1'b1;
    end
    rd_pipe[0] <= mem_word(bus_address[9:2]);
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus_read_data = rd_pipe[RL-1];

  // Scoreboard
  typedef struct {
    logic        id;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_rd(input logic id, input logic [31:0] d);
    sb.push_back('{id, d, cyc + RL});
  endtask

  // Monitor: pops one expected response for each rvalid and flags responses
  // that arrive late, never arrive, or are not expected at all.
  always @(negedge clock) begin
    if (!reset) begin
      if (m0_rvalid && m1_rvalid) chk("both_rvalid", 1, 0);
      if (m0_rvalid || m1_rvalid) begin
        if (sb.size() == 0) chk("stray_rvalid", {m1_rvalid, m0_rvalid}, 0);
        else begin
          mon_e = sb.pop_front();
          chk("rvalid_id", m1_rvalid, mon_e.id);
          chk("rvalid_cycle", cyc, mon_e.due);
          chk("read_data", m1_rvalid ? m1_read_data : m0_read_data, mon_e.data);
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        mon_e = sb.pop_front();
        chk("missing_rvalid", 0, 1);
      end
    end
  end

  task automatic drv(input logic r0, w0, l0, input logic [31:0] a0, d0,
                     input logic r1, w1, l1, input logic [31:0] a1, d1);
    m0_req = r0; m0_write = w0; m0_lock = l0; m0_address = a0; m0_write_data = d0;
    m1_req = r1; m1_write = w1; m1_lock = l1; m1_address = a1; m1_write_data = d1;
    m0_byte_enable = 4'hF; m1_byte_enable = 4'hF;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_gnt(input string name, input logic e0, input logic e1);
    #2;
    chk(name, {m0_gnt, m1_gnt}, {e0, e1});
  endtask

  task automatic chk_bus_zero(input string name);
    chk(name, {bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
               m0_rvalid, m1_rvalid}, 0);
  endtask

  logic exp_pat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    reset = 1'b1;
    drv(1, 0, 0, 32'h100, 0, 1, 0, 0, 32'h4, 0);
    nxt(); nxt();
    chk_gnt("reset_gnt", 0, 0);
    chk_bus_zero("reset_bus");
    idle();
    reset = 1'b0;
    nxt();

    // Idle: nothing on the bus
    for (int i = 0; i < 3; i++) begin
      idle();
      chk_gnt("idle_gnt", 0, 0);
      chk_bus_zero("idle_bus");
      nxt();
    end

    // Single m0 read
    drv(1, 0, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    chk_gnt("t1_gnt", 1, 0);
    chk("t1_bus", {bus_read_enable, bus_write_enable, bus_address}, {2'b10, 32'h100});
    expect_rd(0, 32'hA500_0100);
    nxt();
    idle();
    repeat (3) nxt();

    // Continuous contention: pattern 0,0,0,0,1
    for (int i = 0; i < 10; i++) begin
      drv(1, 0, 0, 32'h0, 0, 1, 0, 0, 32'h4, 0);
      chk_gnt("t2_gnt", !exp_pat[i], exp_pat[i]);
      if (exp_pat[i]) expect_rd(1, 32'hA500_0004);
      else            expect_rd(0, 32'hA500_0000);
      nxt();
    end
    idle();
    repeat (3) nxt();

    // m1 locked write then read; m0 held off
    drv(0, 0, 0, 0, 0, 1, 1, 1, 32'h40, 32'hDEAD_BEEF);
    chk_gnt("t3_wr_gnt", 0, 1);
    chk("t3_wr_bus", {bus_write_enable, bus_read_enable, bus_address, bus_write_data},
        {2'b10, 32'h40, 32'hDEAD_BEEF});
    nxt();
    drv(1, 0, 0, 32'h8, 0, 0, 0, 1, 0, 0);
    chk_gnt("t3_hold_gnt", 0, 0);
    nxt();
    drv(1, 0, 0, 32'h8, 0, 1, 0, 0, 32'h40, 0);
    chk_gnt("t3_rd_gnt", 0, 1);
    expect_rd(1, 32'hDEAD_BEEF);
    nxt();
    drv(1, 0, 0, 32'h8, 0, 0, 0, 0, 0, 0);
    chk_gnt("t3_release_gnt", 1, 0);
    expect_rd(0, 32'hA500_0008);
    nxt();
    idle();
    repeat (3) nxt();

    // m0 lock while m1 starves: counter saturates, m1 wins right after release
    for (int i = 0; i < 6; i++) begin
      drv(1, 0, (i < 5), 32'h0, 0, 1, 0, 0, 32'h4, 0);
      chk_gnt("t3b_lock0_gnt", 1, 0);
      expect_rd(0, 32'hA500_0000);
      nxt();
    end
    drv(1, 0, 0, 32'h0, 0, 1, 0, 0, 32'h4, 0);
    chk_gnt("t3b_starve_win", 0, 1);
    expect_rd(1, 32'hA500_0004);
    nxt();
    chk_gnt("t3b_after_win", 1, 0);
    expect_rd(0, 32'hA500_0000);
    nxt();
    idle();
    repeat (3) nxt();

    // Back-to-back reads from alternating masters
    drv(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    chk_gnt("t4_a", 1, 0);
    expect_rd(0, 32'hA500_0000);
    nxt();
    drv(0, 0, 0, 0, 0, 1, 0, 0, 32'h4, 0);
    chk_gnt("t4_b", 0, 1);
    expect_rd(1, 32'hA500_0004);
    nxt();
    drv(1, 0, 0, 32'h8, 0, 0, 0, 0, 0, 0);
    chk_gnt("t4_c", 1, 0);
    expect_rd(0, 32'hA500_0008);
    nxt();
    idle();
    repeat (4) nxt();

    // Reset with a read in flight
    drv(1, 0, 0, 32'hC, 0, 0, 0, 0, 0, 0);
    chk_gnt("t5_issue", 1, 0);
    nxt();
    reset = 1'b1;
    drv(1, 0, 0, 32'h8, 0, 1, 0, 0, 32'h4, 0);
    chk_gnt("t5_in_reset_gnt", 0, 0);
    chk_bus_zero("t5_in_reset_bus");
    nxt(); nxt();
    reset = 1'b0;
    idle();
    repeat (4) nxt();
    drv(0, 0, 0, 0, 0, 1, 0, 0, 32'h4, 0);
    chk_gnt("t5_after_gnt", 0, 1);
    expect_rd(1, 32'hA500_0004);
    nxt();
    idle();

    for (int i = 0; i < 20 && sb.size() > 0; i++) nxt();
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
